// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulation stage: default widths, FSM
// state encoding, product extension helper and the signed saturation limits.
// Optional build macro used by this slice: MAC_ACC_SAT_EN (saturating accumulate).
package mac_pkg;

    localparam int PW_DEF = 64;   // product width (2x multiplier operand width)
    localparam int AW_DEF = 80;   // accumulator width, PW plus guard bits
    localparam int CW_DEF = 16;   // beat-counter width

    // Working width of the extension helper; any AW up to this is supported.
    localparam int EXT_W  = 128;

    // Signed limits of the accumulator at the default width.
    localparam logic [AW_DEF-1:0] ACC_MAX = {1'b0, {(AW_DEF-1){1'b1}}};
    localparam logic [AW_DEF-1:0] ACC_MIN = {1'b1, {(AW_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no sum open
        ACC  = 2'd1,  // sum open, collecting beats
        HOLD = 2'd2   // completed sum presented downstream
    } state_t;

    // Extend a pw-bit product (zero-padded into EXT_W bits) to EXT_W bits.
    // tc=1 sign-extends, tc=0 zero-extends. Callers truncate to their AW,
    // which preserves the extension for any AW <= EXT_W.
    function automatic logic [EXT_W-1:0] ext_prod(input logic [EXT_W-1:0] prod,
                                                   input int              pw,
                                                   input logic            tc);
        logic [EXT_W-1:0] res;
        logic             sgn;
        res = prod;
        sgn = tc & prod[pw-1];
        for (int i = 0; i < EXT_W; i++) begin
            if (i >= pw) begin
                res[i] = sgn;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_acc_add.sv
// Combinational AW-bit signed adder with overflow flag.
// Ports: a (running sum), b (extended product) -> sum, ovf (signed overflow of a+b).
// With MAC_ACC_SAT_EN defined the sum clamps to the signed max/min on overflow;
// otherwise it wraps modulo 2^AW.
module mac_acc_add #(
    parameter int AW = 80
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [AW-1:0] raw;

    assign raw = a + b;

    // Overflow only when both operands share a sign and the result does not.
    assign ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);

`ifdef MAC_ACC_SAT_EN
    localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

    // On overflow a and b have the same sign, so b's sign picks the rail.
    assign sum = ovf ? (b[AW-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/mac_acc.sv
// Accumulation stage behind mult32x32: sums one PW-bit product per cycle into
// an AW-bit signed accumulator and presents each completed sum on a valid/ready
// handshake. Result is valid the cycle after the last beat is accepted.
// Ports: i_clk/i_rst (async active-high); i_prod_vld/i_prod/i_prod_tc/i_first/
// i_last input beat, o_in_rdy; o_acc/o_cnt/o_ovf/o_acc_vld/i_acc_rdy result;
// o_err_drop sticky flag for beats presented while not ready.
// Optional build macro: MAC_ACC_SAT_EN (saturate instead of wrap, in mac_acc_add).
module mac_acc
    import mac_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_prod_vld,
    input  logic [PW-1:0] i_prod,
    input  logic          i_prod_tc,
    input  logic          i_first,
    input  logic          i_last,
    output logic          o_in_rdy,
    output logic [AW-1:0] o_acc,
    output logic          o_acc_vld,
    input  logic          i_acc_rdy,
    output logic [CW-1:0] o_cnt,
    output logic          o_ovf,
    output logic          o_err_drop
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic          in_rdy;
    logic          accept;
    logic          handoff;
    logic          restart;
    logic [AW-1:0] ext;
    logic [AW-1:0] add_a;
    logic [AW-1:0] sum;
    logic          add_ovf;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_inc;
    logic          ovf_nxt;

    // The upstream multiplier cannot stall, so the only backpressure point is
    // an untaken result in HOLD.
    assign in_rdy   = (state != HOLD) | i_acc_rdy;
    assign o_in_rdy = in_rdy;
    assign accept   = i_prod_vld & in_rdy;
    assign handoff  = (state == HOLD) & i_acc_rdy;

    assign ext = AW'(ext_prod(EXT_W'(i_prod), PW, i_prod_tc));

    // A beat accepted in HOLD can only happen on the handoff cycle, where the
    // running state is cleared first; treat it like a fresh sum.
    assign restart  = i_first | (state == HOLD);
    assign add_a    = restart ? '0 : acc;
    assign cnt_base = restart ? '0 : cnt;
    assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    assign ovf_nxt  = (restart ? 1'b0 : ovf) | add_ovf;

    mac_acc_add #(
        .AW (AW)
    ) u_add (
        .a   (add_a),
        .b   (ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    state_nxt = i_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (i_acc_rdy) begin
                    if (accept) begin
                        state_nxt = i_last ? HOLD : ACC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_acc_vld = (state == HOLD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            o_acc      <= '0;
            o_cnt      <= '0;
            o_ovf      <= 1'b0;
            o_err_drop <= 1'b0;
        end else begin
            state <= state_nxt;

            if (i_prod_vld && !in_rdy) begin
                o_err_drop <= 1'b1;
            end

            if (accept) begin
                acc <= sum;
                cnt <= cnt_inc;
                ovf <= ovf_nxt;
                // Result registers change only when a sum closes, which keeps
                // them stable for the whole HOLD period.
                if (i_last) begin
                    o_acc <= sum;
                    o_cnt <= cnt_inc;
                    o_ovf <= ovf_nxt;
                end
            end else if (handoff) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule
